// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with configurable width and depth.
// Provides occupancy count, almost-full/almost-empty thresholds, an optional
// first-word-fall-through read port, and a synchronous flush. A write while
// full is accepted when a read is accepted in the same cycle.
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 rvalid_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o
);

  localparam logic [PTR_WIDTH:0] CNT_DEPTH = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CNT_AF    = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] CNT_AE    = (PTR_WIDTH+1)'(AE_THRESH);
  localparam logic [PTR_WIDTH:0] CNT_ONE   = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 wr_err_q, wr_err_d;
  logic                 rd_err_q, rd_err_d;
  logic                 rd_acc, wr_acc;

  // Flags are decoded from the registered count only, so no request input
  // reaches a flag combinationally.
  assign full_o         = (count_q == CNT_DEPTH);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CNT_AF);
  assign almost_empty_o = (count_q <= CNT_AE);
  assign count_o        = count_q;
  assign wr_error_o     = wr_err_q;
  assign rd_error_o     = rd_err_q;

  // Acceptance against pre-edge occupancy; a read frees the slot for a write while full.
  assign rd_acc = rd_en_i & ~empty_o;
  assign wr_acc = wr_en_i & (~full_o | rd_acc);

  // Next-state for pointers, count and error pulses; flush overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_err_d = wr_en_i & ~wr_acc;
    rd_err_d = rd_en_i & ~rd_acc;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wr_err_d = 1'b0;
      rd_err_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset; contents are only meaningful between the
    // pointers, and leaving it unreset lets it map onto plain RAM.
    if (wr_acc && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; rd_en_i acknowledges it.
    assign rdata_o  = mem_q[rd_ptr_q];
    assign rvalid_o = ~empty_o;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // Registered read port: data loads on an accepted pop and holds otherwise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else if (clr_i) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
      end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Testbench for fifo_sync_param: one standard-read instance and one FWFT
// instance share the same stimulus and are compared against a queue model.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wdata = '0;

  logic [7:0] rdata0, rdata1;
  logic       rvalid0, rvalid1, full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1, werr0, werr1, rerr0, rerr1;
  logic [4:0] count0, count1;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents plus the standard-port read register.
  logic [7:0] mq[$];
  logic [7:0] m_rdata = '0;
  logic       m_rvalid = 1'b0;
  logic       m_werr = 1'b0;
  logic       m_rerr = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_param #(.FWFT(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(rdata0), .rvalid_o(rvalid0), .full_o(full0),
    .empty_o(empty0), .almost_full_o(af0), .almost_empty_o(ae0), .count_o(count0),
    .wr_error_o(werr0), .rd_error_o(rerr0)
  );

  fifo_sync_param #(.FWFT(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(rdata1), .rvalid_o(rvalid1), .full_o(full1),
    .empty_o(empty1), .almost_full_o(af1), .almost_empty_o(ae1), .count_o(count1),
    .wr_error_o(werr1), .rd_error_o(rerr1)
  );

  function automatic logic [19:0] exp0();
    int n = mq.size();
    return {5'(n), n == 16, n == 0, n >= 12, n <= 4, m_werr, m_rerr, m_rvalid, m_rdata};
  endfunction

  function automatic logic [19:0] got0();
    return {count0, full0, empty0, af0, ae0, werr0, rerr0, rvalid0, rdata0};
  endfunction

  function automatic logic [11:0] exp1();
    int n = mq.size();
    return {5'(n), n == 16, n == 0, n >= 12, n <= 4, m_werr, m_rerr, n != 0};
  endfunction

  function automatic logic [11:0] got1();
    return {count1, full1, empty1, af1, ae1, werr1, rerr1, rvalid1};
  endfunction

  function automatic logic [7:0] head();
    return mq[0];
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_werr   = 1'b0;
    m_rerr   = 1'b0;
  endfunction

  // Apply one clock of stimulus, advance the model, and return #1 after the edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit racc, wacc;
    int n;
    wr_en = w; wdata = d; rd_en = r; clr = c;
    @(posedge clk);
    n = mq.size();
    if (c) begin
      mq.delete();
      m_werr = 1'b0; m_rerr = 1'b0; m_rvalid = 1'b0;
    end else begin
      racc = r && (n > 0);
      wacc = w && ((n < 16) || racc);
      m_werr = w && !wacc;
      m_rerr = r && !racc;
      m_rvalid = racc;
      if (racc) m_rdata = mq.pop_front();
      if (wacc) mq.push_back(d);
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (got0() !== exp0()) begin
      errors++; $display("FAIL power_reset_std: got %h exp %h", got0(), exp0());
    end
    checks++;
    if (got1() !== exp1()) begin
      errors++; $display("FAIL power_reset_fwft: got %h exp %h", got1(), exp1());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    checks++;
    if (got0() !== exp0()) begin
      errors++; $display("FAIL pre_reset_state: got %h exp %h", got0(), exp0());
    end
    // Assert reset between edges and check before any further edge.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (got0() !== exp0()) begin
      errors++; $display("FAIL midseq_reset_std: got %h exp %h", got0(), exp0());
    end
    checks++;
    if (got1() !== exp1()) begin
      errors++; $display("FAIL midseq_reset_fwft: got %h exp %h", got1(), exp1());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (got0() !== exp0()) begin
        errors++; $display("FAIL fill_std[%0d]: got %h exp %h", i, got0(), exp0());
      end
      checks++;
      if (got1() !== exp1() || rdata1 !== head()) begin
        errors++; $display("FAIL fill_fwft[%0d]: got %h/%h exp %h/%h", i, got1(), rdata1, exp1(), head());
      end
    end
    checks++;
    if (full0 !== 1'b1 || count0 !== 5'd16) begin
      errors++; $display("FAIL full_after_16: got full=%b count=%0d exp full=1 count=16", full0, count0);
    end
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    checks++;
    if (werr0 !== 1'b1 || count0 !== 5'd16 || got0() !== exp0()) begin
      errors++; $display("FAIL overflow_write: got %h exp %h", got0(), exp0());
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (got0() !== exp0()) begin
      errors++; $display("FAIL overflow_pulse_clear: got %h exp %h", got0(), exp0());
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (rdata0 !== 8'(i) || rvalid0 !== 1'b1 || got0() !== exp0()) begin
        errors++; $display("FAIL drain_std[%0d]: got %h exp %h", i, got0(), exp0());
      end
      checks++;
      if (got1() !== exp1() || (mq.size() > 0 && rdata1 !== head())) begin
        errors++; $display("FAIL drain_fwft[%0d]: got %h/%h exp %h", i, got1(), rdata1, exp1());
      end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 8'h10 || got0() !== exp0()) begin
      errors++; $display("FAIL drain_idle_hold: got %h exp %h", got0(), exp0());
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++;
    if (werr0 !== 1'b0 || count0 !== 5'd16 || got0() !== exp0()) begin
      errors++; $display("FAIL full_rw: got %h exp %h", got0(), exp0());
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (got0() !== exp0()) begin
        errors++; $display("FAIL full_rw_drain[%0d]: got %h exp %h", i, got0(), exp0());
      end
    end
    checks++;
    if (rdata0 !== 8'hAA) begin
      errors++; $display("FAIL full_rw_last_word: got %h exp aa", rdata0);
    end
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    checks++;
    if (rerr0 !== 1'b1 || count0 !== 5'd1 || got0() !== exp0()) begin
      errors++; $display("FAIL empty_rw_std: got %h exp %h", got0(), exp0());
    end
    checks++;
    if (got1() !== exp1() || rdata1 !== 8'h3C) begin
      errors++; $display("FAIL empty_rw_fwft: got %h/%h exp %h/3c", got1(), rdata1, exp1());
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if (count0 !== 5'd3 || werr0 || rerr0 || got0() !== exp0()) begin
        errors++; $display("FAIL wrap_std[%0d]: got %h exp %h", i, got0(), exp0());
      end
      checks++;
      if (got1() !== exp1() || rdata1 !== head()) begin
        errors++; $display("FAIL wrap_fwft[%0d]: got %h/%h exp %h/%h", i, got1(), rdata1, exp1(), head());
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_fwft_clear();
    cycle(1'b1, 8'h5C, 1'b0, 1'b0);
    checks++;
    if (rdata1 !== 8'h5C || rvalid1 !== 1'b1) begin
      errors++; $display("FAIL fwft_first_word: got %h/%b exp 5c/1", rdata1, rvalid1);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    checks++;
    if (count1 !== 5'd5 || got1() !== exp1()) begin
      errors++; $display("FAIL pre_clear_count: got %h exp %h", got1(), exp1());
    end
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    checks++;
    if (count0 !== 5'd0 || empty0 !== 1'b1 || got0() !== exp0()) begin
      errors++; $display("FAIL clear_std: got %h exp %h", got0(), exp0());
    end
    checks++;
    if (got1() !== exp1()) begin
      errors++; $display("FAIL clear_fwft: got %h exp %h", got1(), exp1());
    end
    cycle(1'b1, 8'hE1, 1'b0, 1'b0);
    checks++;
    if (got1() !== exp1() || rdata1 !== 8'hE1) begin
      errors++; $display("FAIL post_clear_write: got %h/%h exp %h/e1", got1(), rdata1, exp1());
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int wprob;
    for (int i = 0; i < 400; i++) begin
      wprob = ((i / 50) % 2 == 0) ? 8 : 2;
      cycle($urandom_range(0, 9) < wprob, 8'($urandom), $urandom_range(0, 9) < (10 - wprob),
            $urandom_range(0, 59) == 0);
      checks++;
      if (got0() !== exp0()) begin
        errors++; $display("FAIL random_std[%0d]: got %h exp %h", i, got0(), exp0());
      end
      checks++;
      if (got1() !== exp1() || (mq.size() > 0 && rdata1 !== head())) begin
        errors++; $display("FAIL random_fwft[%0d]: got %h/%h exp %h", i, got1(), rdata1, exp1());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_wrap();
    test_fwft_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO; the next-generation buffer alongside the dual-clock FIFO in this library. It adds configurable width and depth, occupancy count, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) read mode, synchronous flush, and accepted write-through-full when a read happens in the same cycle. It is used wherever producer and consumer share one clock domain.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 16, number of entries; power of two, ≥ 4
- PTR_WIDTH, 4, log2(DEPTH); the instantiator must keep it consistent with DEPTH
- AF_THRESH, 12, almost_full_o asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 4, almost_empty_o asserts when count ≤ AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk_i  in  1  single clock; all logic on its rising edge
- rst_n_i  in  1  reset; asynchronous, active-low
- clr_i  in  1  synchronous flush
- wr_en_i  in  1  write request
- wdata_i  in  WIDTH  write data
- rd_en_i  in  1  read request (pop)
- rdata_o  out  WIDTH  read data
- rvalid_o  out  1  rdata_o valid
- full_o, empty_o  out  1 each  occupancy flags
- almost_full_o, almost_empty_o  out  1 each  threshold flags
- count_o  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
- wr_error_o, rd_error_o  out  1 each  rejected-request pulses

## Operation
- State: wr_ptr and rd_ptr (PTR_WIDTH bits each; they wrap naturally from DEPTH-1 to 0), count (PTR_WIDTH+1 bits), and mem[DEPTH]. Memory is not reset.
- Acceptance is evaluated against the pre-edge state:
  - rd_acc = rd_en_i & ~empty_o
  - wr_acc = wr_en_i & (~full_o | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
  - Write while empty with rd_en_i: the write is accepted and the read is rejected.
- Update on each edge:
  - count ← count + wr_acc − rd_acc
  - wr_acc: mem[wr_ptr] ← wdata_i and wr_ptr increments
  - rd_acc: rd_ptr increments
- Flags are decoded from the count register, so they reflect post-edge state:
  - full_o = (count == DEPTH)
  - empty_o = (count == 0)
  - almost_full_o = (count ≥ AF_THRESH)
  - almost_empty_o = (count ≤ AE_THRESH)
  - count_o = count
- Errors:
  - wr_error_o ← wr_en_i & ~wr_acc
  - rd_error_o ← rd_en_i & ~rd_acc
  - Both are registered one-cycle pulses and clear on the next edge without a new violation.
- FWFT=0:
  - On rd_acc, rdata_o ← mem[rd_ptr] and rvalid_o ← 1 for one cycle.
  - Otherwise rvalid_o ← 0 and rdata_o holds its last value.
- FWFT=1:
  - rdata_o = mem[rd_ptr] combinationally; rvalid_o = ~empty_o.
  - rd_en_i acknowledges (pops) the presented word.
- clr_i (synchronous) has priority over wr_en_i and rd_en_i. On the edge it sets:
  - wr_ptr = rd_ptr = count = 0
  - wr_error_o = rd_error_o = 0
  - rvalid_o = 0
  - rdata_o is unchanged in FWFT=0 mode. Memory contents are untouched.
- Reset (rst_n_i low) forces, immediately and independent of clk_i:
  - ptrs, count, rdata_o (FWFT=0) = 0
  - rvalid_o = wr_error_o = rd_error_o = 0
  - empty_o = almost_empty_o = 1; full_o = almost_full_o = 0
  - Assertion mid-transfer discards all contents. Deassertion is taken synchronously by the integrator; the first edge with rst_n_i high is a normal cycle.

## Timing
- Write at edge N: count_o and flags update after edge N.
  - FWFT=0: the earliest accepted read is at edge N+1, with rdata_o/rvalid_o valid after edge N+1.
  - FWFT=1: rdata_o/rvalid_o are valid after edge N (zero extra latency).
- Read throughput is one word per cycle; sustained simultaneous read+write keeps count constant, including at count == DEPTH.
- Error pulses appear after the edge that sampled the rejected request.
- full_o deasserts in the cycle after the read edge; no combinational path from wr_en_i/rd_en_i to any flag.

## Test plan
- Reset with rst_n_i=0 mid-sequence and no clock → empty_o=1, almost_empty_o=1, count_o=0, errors=0, rvalid_o=0 immediately.
- Defaults, FWFT=0: write 0x01..0x10 (16 words) → full_o=1 and count_o=16 after the 16th edge. A 17th write → wr_error_o pulses one cycle; the FIFO is unchanged. Reading 16 words returns 0x01..0x10 in order, each with one-cycle rvalid_o after its read edge.
- Thresholds: track count 0→16→0 → almost_full_o=1 exactly for count ≥12 and almost_empty_o=1 exactly for count ≤4.
- Full with rd_en_i=wr_en_i=1, wdata_i=0xAA → no wr_error_o; count stays 16; 0xAA is returned after the 15 older words. Empty with both high → rd_error_o=1, count becomes 1.
- Wrap-around: run 40 cycles of write/read interleaved with count held at 3 → data order preserved across pointer wrap; no error pulses.
- FWFT=1: single write 0x5C → rdata_o=0x5C, rvalid_o=1 after that edge. With count=5, clr_i=1 together with wr_en_i=1 → count_o=0, empty_o=1, the write is discarded.
